psum_ofifo: RTL and testbench
=============================

PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 SHALL have parameter psum_bw, default 16, partial-sum width per column.
REQ-002 SHALL have parameter col, default 8, number of array columns.
REQ-003 SHALL have parameter depth, default 8, entries per column; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 SHALL have port in  input  psum_bw*col  psums from the bottom array row; column i on bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-007 SHALL have port in_zero  input  col  per-column zero flag accompanying in.
REQ-008 SHALL have port wr  input  col  per-column write strobe; this is the array row's per-column valid.
REQ-009 SHALL have port rd  input  1  pop one full row from all columns.
REQ-010 SHALL have port out  output  psum_bw*col  head entry of each column, same packing as in.
REQ-011 SHALL have port out_zero  output  col  zero flags of the head entries.
REQ-012 SHALL have port o_valid  output  1  every column holds at least one entry.
REQ-013 SHALL have port o_full  output  1  at least one column holds depth entries.
REQ-014 SHALL have port err  output  1  sticky flag: a write was dropped.

Function
REQ-015 SHALL implement one independent circular buffer per column, each entry psum_bw+1 bits (psum plus zero flag).
REQ-016 Each column SHALL keep read and write pointers of log2(depth)+1 bits; the MSB is the wrap bit.
REQ-017 Column empty SHALL be rptr==wptr; column full SHALL be addresses equal with wrap bits differing.
REQ-018 Write: wr[i]=1 and column i not full SHALL store {in_zero[i], in column i} at wptr[i], then increment wptr[i] modulo 2*depth.
REQ-019 Columns SHALL fill independently; skewed wr bits across cycles are the normal case.
REQ-020 o_valid SHALL be the AND of all column not-empty; o_full SHALL be the OR of all column full; both decoded combinationally from the pointers.
REQ-021 Read: rd=1 and o_valid=1 SHALL increment every rptr by one in the same edge.
REQ-022 rd=1 while o_valid=0 SHALL be ignored: no pointer change, no err.
REQ-023 out/out_zero SHALL be first-word-fall-through, combinationally showing each column's head entry while o_valid=1.
REQ-024 out and out_zero SHALL be driven all-zero while o_valid=0.
REQ-025 There SHALL be no write-to-read bypass; an entry written at edge N is visible on out no earlier than after edge N.
REQ-026 A write to a full column SHALL be accepted if a legal pop occurs in the same cycle; the occupancy of that column is unchanged.
REQ-027 A write to a full column with no legal pop in the same cycle SHALL be dropped, leave pointers unchanged, and set err at that edge.
REQ-028 err, once set, SHALL remain 1 until reset.
REQ-029 Pointer wrap-around SHALL be seamless, with no bubble or data loss across the depth boundary.

Reset
REQ-030 While reset=0, regardless of clk, all pointers and err SHALL be 0; outputs SHALL then be o_valid=0, o_full=0, err=0, out=0, out_zero=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries immediately; buffer memory contents need not be cleared.
REQ-032 The first rising edge after reset deasserts SHALL already accept writes.

Verification
REQ-033 Reset then skewed fill: wr=8'h01, 8'h03, ... 8'hFF on consecutive cycles with column i data = i+1 -> o_valid=0 until after the 8th edge, then out = {16'd8, ..., 16'd1}.
REQ-034 FWFT pop: 3 full rows A, B, C written, then rd held high -> out shows A, B, C on consecutive cycles; o_valid falls after the third pop; out=0 afterwards.
REQ-035 Overflow: 9 writes to column 0 only, no rd -> o_full=1 after the 8th edge; 9th write dropped; err=1 and stays 1; column 0 still holds the first 8 values in order.
REQ-036 Full with simultaneous pop: all columns full, then rd=1 and wr=8'hFF with new row D -> no err; o_full stays 1; after 8 further pops D emerges last.
REQ-037 Wrap and reset: 20 rows streamed with interleaved rd (pointers wrap twice) -> order preserved; then reset=0 mid-stream -> o_valid=0 and out=0 immediately, with no clock edge required.
REQ-038 Empty rd and zero flags: rd=1 with empty FIFO -> no change, err=0; a row written with in_zero=8'hA5 -> out_zero=8'hA5 when that row is at the head.

Source files
------------

// File: rtl/psum_ofifo.sv
// Output FIFO for the bottom row of the PE array: one independent circular buffer per column,
// first-word-fall-through, popped as a whole row once every column holds data.
module psum_ofifo #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int depth   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         in_zero,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic [col-1:0]         out_zero,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   err
);

    localparam int aw = $clog2(depth);

    logic [col-1:0] col_empty;
    logic [col-1:0] col_full;
    logic [col-1:0] wr_ok;
    logic [col-1:0] wr_drop;
    logic           pop;

    assign o_valid = &(~col_empty);
    assign o_full  = |col_full;
    assign pop     = rd & o_valid;

    for (genvar g = 0; g < col; g++) begin : g_col
        logic [psum_bw:0] mem [depth];
        logic [aw:0]      rptr;
        logic [aw:0]      wptr;
        logic [psum_bw:0] head;

        assign col_empty[g] = (rptr == wptr);
        assign col_full[g]  = (rptr[aw-1:0] == wptr[aw-1:0]) && (rptr[aw] != wptr[aw]);
        // A full column still takes a write when the row pop frees its head slot this edge.
        assign wr_ok[g]     = wr[g] & (~col_full[g] | pop);
        assign wr_drop[g]   = wr[g] & col_full[g] & ~pop;

        always_ff @(posedge clk) begin
            if (wr_ok[g]) begin
                mem[wptr[aw-1:0]] <= {in_zero[g], in[psum_bw*g +: psum_bw]};
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rptr <= '0;
                wptr <= '0;
            end else begin
                if (wr_ok[g]) begin
                    wptr <= wptr + (aw+1)'(1);
                end
                if (pop) begin
                    rptr <= rptr + (aw+1)'(1);
                end
            end
        end

        assign head                       = mem[rptr[aw-1:0]];
        assign out[psum_bw*g +: psum_bw]  = o_valid ? head[psum_bw-1:0] : '0;
        assign out_zero[g]                = o_valid & head[psum_bw];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (|wr_drop) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: per-column queue model updated per clock edge, compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_psum_ofifo;

    localparam int BW    = 16;
    localparam int COL   = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [BW*COL-1:0] din = '0;
    logic [COL-1:0]   in_zero = '0;
    logic [COL-1:0]   wr = '0;
    logic             rd = 1'b0;
    logic [BW*COL-1:0] out;
    logic [COL-1:0]   out_zero;
    logic             o_valid;
    logic             o_full;
    logic             err;

    int errors = 0;
    int checks = 0;

    logic [BW:0] q [COL][$];
    logic        err_m = 1'b0;

    psum_ofifo #(.psum_bw(BW), .col(COL), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .in(din), .in_zero(in_zero), .wr(wr), .rd(rd),
        .out(out), .out_zero(out_zero), .o_valid(o_valid), .o_full(o_full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < COL; i++) q[i].delete();
        err_m = 1'b0;
    endtask

    task automatic model_edge(input logic [COL-1:0] w, input logic [BW*COL-1:0] d,
                              input logic [COL-1:0] z, input logic r);
        bit p = r;
        for (int i = 0; i < COL; i++) if (q[i].size() == 0) p = 0;
        for (int i = 0; i < COL; i++) begin
            if (w[i]) begin
                if (q[i].size() < DEPTH || p) q[i].push_back({z[i], d[i*BW +: BW]});
                else err_m = 1'b1;
            end
        end
        if (p) for (int i = 0; i < COL; i++) void'(q[i].pop_front());
    endtask

    // Inputs applied 1 time unit after an edge; model advanced on the edge with the same values.
    task automatic step(input logic [COL-1:0] w, input logic [BW*COL-1:0] d,
                        input logic [COL-1:0] z, input logic r);
        wr = w; din = d; in_zero = z; rd = r;
        @(posedge clk);
        if (reset) model_edge(w, d, z, r);
        #1;
    endtask

    task automatic idle();
        step('0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        model_clear();
        wr = '0; rd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    function automatic logic [BW*COL-1:0] rand_row();
        logic [BW*COL-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic              ev, ef;
        logic [BW*COL-1:0] eo;
        logic [COL-1:0]    ez;
        ev = 1'b1; ef = 1'b0; eo = '0; ez = '0;
        for (int i = 0; i < COL; i++) begin
            if (q[i].size() == 0) ev = 1'b0;
            if (q[i].size() == DEPTH) ef = 1'b1;
        end
        if (ev) begin
            for (int i = 0; i < COL; i++) begin
                eo[i*BW +: BW] = q[i][0][BW-1:0];
                ez[i]          = q[i][0][BW];
            end
        end
        chk("cyc_o_valid", o_valid, ev);
        chk("cyc_o_full", o_full, ef);
        chk("cyc_err", err, err_m);
        chk("cyc_out", out, eo);
        chk("cyc_out_zero", out_zero, ez);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW*COL-1:0] row_a, row_d;
        logic [COL-1:0]    w;

        // Reset state
        #2;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_full", o_full, 0);
        chk("rst_err", err, 0);
        chk("rst_out", out, 0);
        chk("rst_out_zero", out_zero, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Skewed fill, column i carries i+1
        row_a = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        for (int k = 0; k < COL; k++) begin
            w = COL'((1 << (k + 1)) - 1);
            step(w, row_a, '0, 1'b0);
            if (k == COL - 2) chk("skew_valid_early", o_valid, 0);
        end
        chk("skew_valid", o_valid, 1);
        chk("skew_out", out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("skew_full", o_full, 1);
        do_reset();

        // FWFT pop of three rows
        for (int k = 0; k < 3; k++) step('1, rand_row(), COL'($urandom), 1'b0);
        for (int k = 0; k < 4; k++) step('0, '0, '0, 1'b1);
        chk("fwft_valid_end", o_valid, 0);
        chk("fwft_out_end", out, 0);
        chk("fwft_err_end", err, 0);
        do_reset();

        // Overflow on column 0
        for (int k = 0; k < 9; k++) begin
            step(8'h01, 128'(100 + k), '0, 1'b0);
            if (k == 7) chk("ovf_full", o_full, 1);
            if (k == 7) chk("ovf_err_before", err, 0);
        end
        chk("ovf_err", err, 1);
        for (int k = 0; k < DEPTH; k++) step(8'hFE, rand_row(), '0, 1'b0);
        chk("ovf_head", out[BW-1:0], 100);
        for (int k = 0; k < DEPTH; k++) step('0, '0, '0, 1'b1);
        chk("ovf_err_sticky", err, 1);
        do_reset();

        // Full with simultaneous pop and write
        for (int k = 0; k < DEPTH; k++) step('1, rand_row(), '0, 1'b0);
        row_d = rand_row();
        step('1, row_d, 8'h3C, 1'b1);
        chk("fullpop_err", err, 0);
        chk("fullpop_full", o_full, 1);
        for (int k = 0; k < DEPTH - 1; k++) step('0, '0, '0, 1'b1);
        chk("fullpop_d_last", out, row_d);
        chk("fullpop_dz_last", out_zero, 8'h3C);
        step('0, '0, '0, 1'b1);
        chk("fullpop_empty", o_valid, 0);
        do_reset();

        // Random stream with wrap-around
        for (int k = 0; k < 300; k++) begin
            w = ($urandom % 4 == 0) ? COL'($urandom) : '1;
            step(w, rand_row(), COL'($urandom), ($urandom % 3) != 0);
        end
        for (int k = 0; k < 3; k++) step('1, rand_row(), '0, 1'b0);
        // Mid-stream reset, no clock edge
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_out", out, 0);
        chk("midrst_err", err, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Empty read, then zero flags
        step('0, '0, '0, 1'b1);
        chk("emptyrd_err", err, 0);
        chk("emptyrd_valid", o_valid, 0);
        step('1, rand_row(), 8'hA5, 1'b0);
        chk("zero_flags", out_zero, 8'hA5);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
